cypherdb_delay_pulse_gen: RTL and testbench
===========================================

// Module: cypherdb_delay_pulse_gen
// PURPOSE
//  Parametrised delayed-start pulse generator for the or1200 CypherDB datapath.
//  - Detects a rising edge on in and captures the ra/rb operand addresses.
//  - Asserts start_stall for a programmable number of cycles, then emits a pulse
//    of configurable width.
//  - Buffers one further request that arrives while busy; adds abort and overflow flag.
// PARAMETERS
//  AW         5  width of ra/rb/cache_ra/cache_rb
//  CNT_W      4  width of delay counter and delay_cfg
//  DEF_DELAY  5  delay value used when cfg_use=0 (must fit in CNT_W bits)
//  PULSE_W    1  pulse length in cycles (>=1)
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  rst        in   1      asynchronous reset, active-high
//  in         in   1      request; rising edge (in=1, previous sample 0) = request
//  ra         in   AW     operand address A, sampled with accepted edge
//  rb         in   AW     operand address B, sampled with accepted edge
//  cfg_use    in   1      1: use delay_cfg; 0: use DEF_DELAY
//  delay_cfg  in   CNT_W  programmable delay, sampled when a request is launched
//  abort      in   1      synchronous cancel of current and pending request
//  start_stall out 1      high while state==DELAY (combinational decode of state reg)
//  busy       out  1      (state!=IDLE) | pend_vld
//  pulse      out  1      high while state==FIRE (decode of state reg)
//  cache_ra   out  AW     address A of the request in flight
//  cache_rb   out  AW     address B of the request in flight
//  pend_ovf   out  1      registered, one-cycle: request dropped, pending slot full
// BEHAVIOUR
//  Reset values:
//  - state=IDLE, counter=0, pend_vld=0, pend_ra/rb=0, cache_ra/rb=0, pend_ovf=0.
//  - in_d resets to 1, so in held high through reset release is not a request.
//  Edge detect: edge = in & ~in_d; in_d <= in every cycle.
//  Delay value D = cfg_use ? delay_cfg : DEF_DELAY, latched into counter at launch.
//  States (2-bit reg): IDLE, DELAY, FIRE. Priority per cycle: abort > FSM > capture.
//  IDLE on edge:
//  - cache_ra/rb <= ra/rb; counter <= D; state <= DELAY.
//  DELAY:
//  - counter!=0: counter <= counter-1, stay.
//  - counter==0: pcnt <= PULSE_W-1, state <= FIRE.
//  - Hence DELAY lasts exactly D+1 cycles (D=0 -> 1 cycle).
//  FIRE:
//  - pcnt!=0: pcnt <= pcnt-1, stay. FIRE lasts PULSE_W cycles.
//  - On the last FIRE cycle, pend_vld=1 (incl. one set this cycle): cache <= pend,
//    counter <= D, pend_vld <= 0, state <= DELAY. Next request launches back-to-back,
//    no IDLE gap.
//  - Otherwise state <= IDLE.
//  Edge while state!=IDLE:
//  - pend_vld=0: pend_ra/rb <= ra/rb, pend_vld <= 1.
//  - pend_vld=1 and not consumed this cycle: request dropped, pend_ovf=1 next cycle.
//  - If pend_vld is being consumed this cycle, the new edge is stored into pend.
//  abort=1:
//  - Next cycle: state=IDLE, counter=0, pend_vld=0. Pulse/stall drop after one cycle.
//  - A pulse already in FIRE is truncated.
//  - cache_ra/rb hold their values. An edge in the same cycle is ignored.
//  Width rules:
//  - Counter decrements never underflow: zero is checked before decrement.
//  - pcnt width = $clog2(PULSE_W+1).
//  Reset mid-operation: immediate return to the reset values; no pulse emitted.
// TESTING
//  T1 DEF_DELAY=5, cfg_use=0. Edge sampled at cycle 0, ra=3, rb=7.
//     -> cache=3/7 from cycle 1; stall cycles 1-6; pulse cycle 7 only; busy cycles 1-7.
//  T2 cfg_use=1, delay_cfg=0. Edge at cycle 0.
//     -> stall cycle 1 only; pulse cycle 2; idle cycle 3.
//  T3 Edge at cycle 0 (ra=1), second edge at cycle 3 (ra=9).
//     -> pulse cycle 7; cache_ra=9 from cycle 8; stall 8-13; pulse 14.
//  T4 Edges at cycles 0, 3, 5. -> third dropped; pend_ovf=1 at cycle 6 only; two pulses.
//  T5 Edge at 0, edge at 2, abort at 4.
//     -> stall low from 5; no pulse ever; busy=0 at 5; cache_ra unchanged.
//  T6 in=1 through reset release; PULSE_W=3; later edge.
//     -> no request at release; later edge gives pulse high 3 consecutive cycles.

Source files
------------

// File: rtl/cypherdb_delay_pulse_gen.sv
// Delayed-start pulse generator for the CypherDB datapath.
// A rising edge on `in` launches a request: start_stall is held for D+1
// cycles, then pulse is held for PULSE_W cycles. One further request can
// wait in a pending slot while busy; a request that finds the slot full is
// dropped and reported on pend_ovf. abort cancels the request in flight and
// the pending one.
//
// Handshake: there is no back-pressure. A request is a single-cycle rising
// edge of `in`. It is either launched (IDLE), stored in the pending slot
// (busy, slot free or being emptied this cycle), or dropped with a one-cycle
// pend_ovf report. ra/rb are sampled in the same cycle as the edge.
module cypherdb_delay_pulse_gen #(
   parameter int AW        = 5,
   parameter int CNT_W     = 4,
   parameter int DEF_DELAY = 5,
   parameter int PULSE_W   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in,
   input  logic [AW-1:0]    ra,
   input  logic [AW-1:0]    rb,
   input  logic             cfg_use,
   input  logic [CNT_W-1:0] delay_cfg,
   input  logic             abort,
   output logic             start_stall,
   output logic             busy,
   output logic             pulse,
   output logic [AW-1:0]    cache_ra,
   output logic [AW-1:0]    cache_rb,
   output logic             pend_ovf
);

   localparam int PCW = $clog2(PULSE_W + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      FIRE  = 2'd2
   } state_t;

   state_t           state_q,    state_d;
   logic [CNT_W-1:0] cnt_q,      cnt_d;
   logic [PCW-1:0]   pcnt_q,     pcnt_d;
   logic             pend_vld_q, pend_vld_d;
   logic [AW-1:0]    pend_ra_q,  pend_ra_d;
   logic [AW-1:0]    pend_rb_q,  pend_rb_d;
   logic [AW-1:0]    cache_ra_q, cache_ra_d;
   logic [AW-1:0]    cache_rb_q, cache_rb_d;
   logic             pend_ovf_q, pend_ovf_d;
   logic             in_d_q,     in_d_d;

   logic             req_edge;
   logic [CNT_W-1:0] dly_val;
   logic             pend_consumed;
   logic             edge_launched;

   // Next-state and datapath: abort first, then the FSM, then pending capture.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      pcnt_d        = pcnt_q;
      pend_vld_d    = pend_vld_q;
      pend_ra_d     = pend_ra_q;
      pend_rb_d     = pend_rb_q;
      cache_ra_d    = cache_ra_q;
      cache_rb_d    = cache_rb_q;
      pend_ovf_d    = 1'b0;
      in_d_d        = in;
      pend_consumed = 1'b0;
      edge_launched = 1'b0;
      req_edge      = in & ~in_d_q;
      dly_val       = cfg_use ? delay_cfg : CNT_W'(DEF_DELAY);

      if (abort) begin
         // Cache keeps the last addresses; any same-cycle edge is discarded.
         state_d    = IDLE;
         cnt_d      = '0;
         pcnt_d     = '0;
         pend_vld_d = 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_edge) begin
                  cache_ra_d    = ra;
                  cache_rb_d    = rb;
                  cnt_d         = dly_val;
                  state_d       = DELAY;
                  edge_launched = 1'b1;
               end
            end
            DELAY: begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  pcnt_d  = PCW'(PULSE_W - 1);
                  state_d = FIRE;
               end
            end
            FIRE: begin
               if (pcnt_q != '0) begin
                  pcnt_d = pcnt_q - PCW'(1);
               end else if (pend_vld_q) begin
                  // Back-to-back launch of the waiting request.
                  cache_ra_d    = pend_ra_q;
                  cache_rb_d    = pend_rb_q;
                  cnt_d         = dly_val;
                  pend_vld_d    = 1'b0;
                  state_d       = DELAY;
                  pend_consumed = 1'b1;
               end else if (req_edge) begin
                  // A request arriving on the last pulse cycle goes straight in.
                  cache_ra_d    = ra;
                  cache_rb_d    = rb;
                  cnt_d         = dly_val;
                  state_d       = DELAY;
                  edge_launched = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase

         if (req_edge && (state_q != IDLE) && !edge_launched) begin
            if (!pend_vld_q || pend_consumed) begin
               pend_ra_d  = ra;
               pend_rb_d  = rb;
               pend_vld_d = 1'b1;
            end else begin
               pend_ovf_d = 1'b1;
            end
         end
      end
   end

   // State register; in_d resets high so a level held through reset is not a request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         pcnt_q     <= '0;
         pend_vld_q <= 1'b0;
         pend_ra_q  <= '0;
         pend_rb_q  <= '0;
         cache_ra_q <= '0;
         cache_rb_q <= '0;
         pend_ovf_q <= 1'b0;
         in_d_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         pcnt_q     <= pcnt_d;
         pend_vld_q <= pend_vld_d;
         pend_ra_q  <= pend_ra_d;
         pend_rb_q  <= pend_rb_d;
         cache_ra_q <= cache_ra_d;
         cache_rb_q <= cache_rb_d;
         pend_ovf_q <= pend_ovf_d;
         in_d_q     <= in_d_d;
      end
   end

   assign start_stall = (state_q == DELAY);
   assign pulse       = (state_q == FIRE);
   assign busy        = (state_q != IDLE) | pend_vld_q;
   assign cache_ra    = cache_ra_q;
   assign cache_rb    = cache_rb_q;
   assign pend_ovf    = pend_ovf_q;

endmodule

// File: tb/tb_cypherdb_delay_pulse_gen.sv
// Bench for cypherdb_delay_pulse_gen: two instances (PULSE_W=1 and 3) share
// stimulus. A schedule model predicts, per request, the launch cycle and the
// stall/pulse windows from the launch time, delay and pulse width.
module tb_cypherdb_delay_pulse_gen;

   localparam int AW  = 5;
   localparam int CW  = 4;
   localparam int DEF = 5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_in = 1'b0;
   logic [AW-1:0] ra = '0;
   logic [AW-1:0] rb = '0;
   logic          cfg_use = 1'b0;
   logic [CW-1:0] delay_cfg = '0;
   logic          abort = 1'b0;

   logic          o_stall [2];
   logic          o_busy  [2];
   logic          o_pulse [2];
   logic [AW-1:0] o_cra   [2];
   logic [AW-1:0] o_crb   [2];
   logic          o_ovf   [2];

   int checks = 0;
   int errors = 0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- DUTs ----------------
   cypherdb_delay_pulse_gen #(.AW(AW), .CNT_W(CW), .DEF_DELAY(DEF), .PULSE_W(1)) u_dut0 (
      .clk(clk), .rst(rst), .in(req_in), .ra(ra), .rb(rb), .cfg_use(cfg_use),
      .delay_cfg(delay_cfg), .abort(abort), .start_stall(o_stall[0]), .busy(o_busy[0]),
      .pulse(o_pulse[0]), .cache_ra(o_cra[0]), .cache_rb(o_crb[0]), .pend_ovf(o_ovf[0])
   );

   cypherdb_delay_pulse_gen #(.AW(AW), .CNT_W(CW), .DEF_DELAY(DEF), .PULSE_W(3)) u_dut1 (
      .clk(clk), .rst(rst), .in(req_in), .ra(ra), .rb(rb), .cfg_use(cfg_use),
      .delay_cfg(delay_cfg), .abort(abort), .start_stall(o_stall[1]), .busy(o_busy[1]),
      .pulse(o_pulse[1]), .cache_ra(o_cra[1]), .cache_rb(o_crb[1]), .pend_ovf(o_ovf[1])
   );

   // ---------------- model ----------------
   // t is the index of the cycle whose outputs are currently visible.
   int            t;
   bit            prev_in;
   bit            m_act    [2];
   int            m_launch [2];
   int            m_d      [2];
   bit            m_pv     [2];
   logic [AW-1:0] m_pra    [2];
   logic [AW-1:0] m_prb    [2];
   logic [AW-1:0] m_cra    [2];
   logic [AW-1:0] m_crb    [2];
   bit            m_ovf    [2];

   function automatic int pw_of(input int i);
      return (i == 0) ? 1 : 3;
   endfunction

   function automatic bit e_stall(input int i);
      int rel;
      rel = t - m_launch[i];
      return m_act[i] && rel >= 1 && rel <= m_d[i] + 1;
   endfunction

   function automatic bit e_pulse(input int i);
      int rel;
      rel = t - m_launch[i];
      return m_act[i] && rel >= m_d[i] + 2 && rel <= m_d[i] + 1 + pw_of(i);
   endfunction

   function automatic bit e_busy(input int i);
      return m_act[i] || m_pv[i];
   endfunction

   task automatic model_reset();
      t       = 0;
      prev_in = 1'b1;
      for (int i = 0; i < 2; i++) begin
         m_act[i]    = 1'b0;
         m_launch[i] = 0;
         m_d[i]      = 0;
         m_pv[i]     = 1'b0;
         m_pra[i]    = '0;
         m_prb[i]    = '0;
         m_cra[i]    = '0;
         m_crb[i]    = '0;
         m_ovf[i]    = 1'b0;
      end
   endtask

   task automatic launch(input int i, input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input int dv);
      m_act[i]    = 1'b1;
      m_launch[i] = t;
      m_d[i]      = dv;
      m_cra[i]    = a;
      m_crb[i]    = b;
   endtask

   task automatic model_step();
      bit e;
      int dv;
      e       = req_in && !prev_in;
      prev_in = req_in;
      dv      = cfg_use ? int'(delay_cfg) : DEF;
      for (int i = 0; i < 2; i++) begin
         int rel;
         bit last;
         rel      = t - m_launch[i];
         last     = m_act[i] && (rel == m_d[i] + 1 + pw_of(i));
         m_ovf[i] = 1'b0;
         if (abort) begin
            m_act[i] = 1'b0;
            m_pv[i]  = 1'b0;
         end else if (!m_act[i]) begin
            if (e) launch(i, ra, rb, dv);
         end else if (last) begin
            if (m_pv[i]) begin
               launch(i, m_pra[i], m_prb[i], dv);
               m_pv[i] = e;
               if (e) begin
                  m_pra[i] = ra;
                  m_prb[i] = rb;
               end
            end else if (e) begin
               launch(i, ra, rb, dv);
            end else begin
               m_act[i] = 1'b0;
            end
         end else if (e) begin
            if (!m_pv[i]) begin
               m_pv[i]  = 1'b1;
               m_pra[i] = ra;
               m_prb[i] = rb;
            end else begin
               m_ovf[i] = 1'b1;
            end
         end
      end
      t++;
   endtask

   // Model advances on each active edge the DUT sees out of reset.
   always @(posedge clk) begin
      if (!rst) model_step();
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%0h exp=%0h", nm, t, got, exp);
      end
   endtask

   // Compare every DUT output against the model on every falling edge.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("stall%0d", i), 32'(o_stall[i]), 32'(e_stall(i)));
         chk($sformatf("pulse%0d", i), 32'(o_pulse[i]), 32'(e_pulse(i)));
         chk($sformatf("busy%0d", i),  32'(o_busy[i]),  32'(e_busy(i)));
         chk($sformatf("cra%0d", i),   32'(o_cra[i]),   32'(m_cra[i]));
         chk($sformatf("crb%0d", i),   32'(o_crb[i]),   32'(m_crb[i]));
         chk($sformatf("ovf%0d", i),   32'(o_ovf[i]),   32'(m_ovf[i]));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic settle();
      req_in = 1'b0;
      abort  = 1'b1;
      step();
      abort  = 1'b0;
      step();
      step();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      model_reset();
      step();
      step();
      // Reset state pinned directly.
      chk("rst_busy", 32'(o_busy[0]), 32'd0);
      chk("rst_cra", 32'(o_cra[0]), 32'd0);
      chk("rst_ovf", 32'(o_ovf[1]), 32'd0);
      rst = 1'b0;
      settle();

      // T1: default delay 5, ra=3 rb=7.
      cfg_use = 1'b0; req_in = 1'b1; ra = 5'd3; rb = 5'd7;
      step();
      req_in = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         chk("t1_stall", 32'(e_stall(0)), 32'(k <= 6));
         chk("t1_pulse", 32'(e_pulse(0)), 32'(k == 7));
         chk("t1_busy",  32'(e_busy(0)),  32'(k <= 7));
         chk("t1_cra",   32'(m_cra[0]),   32'd3);
         chk("t1_crb",   32'(m_crb[0]),   32'd7);
         step();
      end
      settle();

      // T2: programmed delay 0.
      cfg_use = 1'b1; delay_cfg = 4'd0; req_in = 1'b1; ra = 5'd2;
      step();
      req_in = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         chk("t2_stall", 32'(e_stall(0)), 32'(k == 1));
         chk("t2_pulse", 32'(e_pulse(0)), 32'(k == 2));
         chk("t2_busy",  32'(e_busy(0)),  32'(k <= 2));
         step();
      end
      cfg_use = 1'b0;
      settle();

      // T3: second request waits and launches back-to-back.
      req_in = 1'b1; ra = 5'd1; rb = 5'd2;
      step();
      req_in = 1'b0;
      step();
      step();
      req_in = 1'b1; ra = 5'd9; rb = 5'd10;
      step();
      req_in = 1'b0;
      for (int k = 4; k <= 15; k++) begin
         chk("t3_pulse", 32'(e_pulse(0)), 32'(k == 7 || k == 14));
         chk("t3_stall", 32'(e_stall(0)), 32'(k <= 6 || (k >= 8 && k <= 13)));
         chk("t3_cra",   32'(m_cra[0]),   (k >= 8) ? 32'd9 : 32'd1);
         step();
      end
      settle();

      // T4: third request dropped.
      req_in = 1'b1; ra = 5'd1; step();
      req_in = 1'b0; step();
      step();
      req_in = 1'b1; ra = 5'd2; step();
      req_in = 1'b0; step();
      req_in = 1'b1; ra = 5'd3; step();
      req_in = 1'b0;
      for (int k = 6; k <= 16; k++) begin
         chk("t4_ovf",   32'(m_ovf[0]),   32'(k == 6));
         chk("t4_pulse", 32'(e_pulse(0)), 32'(k == 7 || k == 14));
         chk("t4_busy",  32'(e_busy(0)),  32'(k <= 14));
         if (k >= 8) chk("t4_cra", 32'(m_cra[0]), 32'd2);
         step();
      end
      settle();

      // T5: abort with a request pending.
      req_in = 1'b1; ra = 5'd4; step();
      req_in = 1'b0; step();
      req_in = 1'b1; ra = 5'd6; step();
      req_in = 1'b0; step();
      chk("t5_stall4", 32'(e_stall(0)), 32'd1);
      abort = 1'b1; step();
      abort = 1'b0;
      for (int k = 5; k <= 12; k++) begin
         chk("t5_stall", 32'(e_stall(0)), 32'd0);
         chk("t5_pulse", 32'(e_pulse(0)), 32'd0);
         chk("t5_busy",  32'(e_busy(0)),  32'd0);
         chk("t5_cra",   32'(m_cra[0]),   32'd4);
         step();
      end

      // T6: level held through reset is not a request; 3-cycle pulse later.
      req_in = 1'b1;
      do_reset();
      for (int k = 0; k < 3; k++) begin
         chk("t6_norel", 32'(e_busy(1)), 32'd0);
         step();
      end
      req_in = 1'b0; step();
      req_in = 1'b1; cfg_use = 1'b0; step();
      req_in = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         chk("t6_pulse1", 32'(e_pulse(1)), 32'(k >= 7 && k <= 9));
         chk("t6_pulse0", 32'(e_pulse(0)), 32'(k == 7));
         step();
      end
      settle();

      // Random traffic with occasional abort and mid-operation reset.
      for (int n = 0; n < 4000; n++) begin
         req_in    = 1'($urandom_range(0, 1));
         abort     = ($urandom_range(0, 49) == 0);
         cfg_use   = 1'($urandom_range(0, 1));
         delay_cfg = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 15))
                                                 : CW'($urandom_range(0, 4));
         ra        = AW'($urandom_range(0, 31));
         rb        = AW'($urandom_range(0, 31));
         if ($urandom_range(0, 699) == 0) do_reset();
         else step();
      end
      abort = 1'b0;
      req_in = 1'b0;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
